// File: rtl/hilo_muldiv_if.sv
// Bundles the issue-side signals of the HI/LO multiply/divide unit.
// With MULDIV_DIVZERO_EXC_EN defined, the interface also carries the divide-by-zero pulse.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             cancel;
    logic             wHi;
    logic             wLo;
    logic [WIDTH-1:0] wData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EXC_EN
    logic             divZero;

    modport master (
        output start, op, srcA, srcB, cancel, wHi, wLo, wData,
        input  busy, done, hi, lo, divZero
    );
    modport slave (
        input  start, op, srcA, srcB, cancel, wHi, wLo, wData,
        output busy, done, hi, lo, divZero
    );
`else
    modport master (
        output start, op, srcA, srcB, cancel, wHi, wLo, wData,
        input  busy, done, hi, lo
    );
    modport slave (
        input  start, op, srcA, srcB, cancel, wHi, wLo, wData,
        output busy, done, hi, lo
    );
`endif
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Optional feature: MULDIV_DIVZERO_EXC_EN turns a zero divisor into a divZero pulse.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIVEND} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             sgn_q, sgn_d, negQuo_q, negQuo_d, negRem_q, negRem_d;
    logic             done_q, done_d;
`ifdef MULDIV_DIVZERO_EXC_EN
    logic             divZero_q, divZero_d;
`endif

    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] extA, extB, product;
    logic [WIDTH:0]     shifted, diff;

    // Division runs on magnitudes; signs are reapplied when the result is written.
    assign absA    = (~bus.op[0] && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
    assign absB    = (~bus.op[0] && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
    assign extA    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign extB    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = extA * extB;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        negQuo_d = negQuo_q;
        negRem_d = negRem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
        divZero_d = 1'b0;
`endif
        if (bus.wHi) hi_d = bus.wData;
        if (bus.wLo) lo_d = bus.wData;

        // A result write later in this block overrides MTHI/MTLO on the same edge.
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_d  = bus.op[1] ? DIV : MUL;
                    cnt_d    = '0;
                    a_d      = bus.srcA;
                    b_d      = bus.srcB;
                    sgn_d    = ~bus.op[0];
                    quo_d    = absA;
                    rem_d    = '0;
                    dvs_d    = absB;
                    negQuo_d = ~bus.op[0] & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
                    negRem_d = ~bus.op[0] & bus.srcA[WIDTH-1];
                end
            end
            MUL: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                end
            end
            DIV: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (b_q == '0) begin
                    state_d = IDLE;
`ifdef MULDIV_DIVZERO_EXC_EN
                    divZero_d = 1'b1;
`else
                    hi_d   = a_q;
                    lo_d   = '1;
                    done_d = 1'b1;
`endif
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DIVEND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DIVEND: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    lo_d   = negQuo_q ? -quo_q : quo_q;
                    hi_d   = negRem_q ? -rem_q : rem_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
            divZero_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            negQuo_q <= negQuo_d;
            negRem_q <= negRem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIVZERO_EXC_EN
            divZero_q <= divZero_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
    assign bus.divZero = divZero_q;
`endif
endmodule
